// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: shared frame layout, FSM encoding and ID constant for the AFE SPI slave
package afe_spi_pkg;
  localparam int FRAME_BITS = 24;
  localparam int CMD_BITS = 8;
  localparam int RW_BIT = 23;
  localparam int ADDR_MSB = 22;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam logic [15:0] ID_VALUE = 16'hAF01;
  typedef enum logic [1:0] {IDLE, CMD, DATA, LATCH} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer plus edge detector for one asynchronous SPI line
module spi_sync_edge #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (rst) {s1, s2, s3} <= {3{IDLE_LVL}};
    else {s1, s2, s3} <= {d, s1, s2};
  end
  assign q = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_afe_slave.sv
// spi_afe_slave: mode-0 SPI register slave with 24-bit R/W frames and malformed-frame counting
module spi_afe_slave #(
  parameter logic [15:0] ID_VALUE = afe_spi_pkg::ID_VALUE,
  parameter int NUM_REGS = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        spi_clk_i,
  input  logic        spi_mosi_i,
  input  logic        spi_sel_i,
  output logic        spi_miso_o,
  output logic        wr_strobe_o,
  output logic [6:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic [7:0]  frame_err_cnt_o,
  output logic        busy_o
);
  import afe_spi_pkg::*;
  state_t state, state_nx;
  logic sclk_rise, sclk_fall, sclk_q_unused;
  logic mosi, mosi_rise_unused, mosi_fall_unused;
  logic sel_q, sel_rise, sel_fall;
  logic [4:0] bit_cnt;
  logic [23:0] shift_in;
  logic [15:0] shift_out, rd_val;
  logic [15:0] regs [1:NUM_REGS-1];
  logic [1:0] settle;
  logic armed, start, clk_take, cmd_done, frame_ok, commit;
  logic [6:0] cmd_addr, frame_addr;
  spi_sync_edge #(.IDLE_LVL(1'b0)) u_clk (.clk(sys_clk), .rst(sys_rst), .d(spi_clk_i),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.IDLE_LVL(1'b0)) u_mosi (.clk(sys_clk), .rst(sys_rst), .d(spi_mosi_i),
    .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
  spi_sync_edge #(.IDLE_LVL(1'b1)) u_sel (.clk(sys_clk), .rst(sys_rst), .d(spi_sel_i),
    .q(sel_q), .rise(sel_rise), .fall(sel_fall));
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? CMD : IDLE;
      CMD:     state_nx = sel_rise ? LATCH : cmd_done ? DATA : CMD;
      DATA:    state_nx = sel_rise ? LATCH : DATA;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    start = sel_fall & armed;
    clk_take = sclk_rise && (state == CMD || state == DATA) && bit_cnt < 5'(FRAME_BITS);
    cmd_done = clk_take && state == CMD && bit_cnt == 5'(CMD_BITS - 1);
    cmd_addr = {shift_in[5:0], mosi};
    frame_addr = shift_in[ADDR_MSB:ADDR_LSB];
    frame_ok = bit_cnt == 5'(FRAME_BITS);
    commit = state == LATCH && frame_ok && !shift_in[RW_BIT] && frame_addr != 7'd0
      && 32'(frame_addr) < NUM_REGS;
    busy_o = state != IDLE;
  end
  always_comb begin
    rd_val = cmd_addr == 7'd0 ? ID_VALUE : 16'h0000;
    for (int i = 1; i < NUM_REGS; i++) if (32'(cmd_addr) == i) rd_val = regs[i];
  end
  // a select already low when reset releases must not start a frame; wait to see it high first
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bit_cnt <= '0;
      shift_in <= '0;
      shift_out <= '0;
      spi_miso_o <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      frame_err_cnt_o <= '0;
      settle <= '0;
      armed <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      settle <= settle == 2'd3 ? settle : settle + 2'd1;
      armed <= armed | (settle == 2'd3 && sel_q);
      wr_strobe_o <= commit;
      if (start) bit_cnt <= '0;
      else if (clk_take) begin
        bit_cnt <= bit_cnt + 5'd1;
        shift_in <= {shift_in[22:0], mosi};
      end
      if (cmd_done) shift_out <= shift_in[6] ? rd_val : 16'h0000;
      else if (state == DATA && sclk_fall) shift_out <= {shift_out[14:0], 1'b0};
      spi_miso_o <= state_nx == DATA ? (state == DATA && sclk_fall ? shift_out[15] : spi_miso_o) : 1'b0;
      if (commit) begin
        wr_addr_o <= frame_addr;
        wr_data_o <= shift_in[DATA_MSB:0];
      end
      for (int i = 1; i < NUM_REGS; i++) if (commit && 32'(frame_addr) == i) regs[i] <= shift_in[DATA_MSB:0];
      if (state == LATCH && !frame_ok && frame_err_cnt_o != 8'hFF) frame_err_cnt_o <= frame_err_cnt_o + 8'd1;
    end
  end
endmodule

// File: tb/tb_spi_afe_slave.sv
// tb_spi_afe_slave: scoreboard bench driving mode-0 SPI frames against a register model
module tb_spi_afe_slave;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic spi_clk_i = 1'b0;
  logic spi_mosi_i = 1'b0;
  logic spi_sel_i = 1'b1;
  logic spi_miso_o, wr_strobe_o, busy_o;
  logic [6:0] wr_addr_o;
  logic [15:0] wr_data_o;
  logic [7:0] frame_err_cnt_o;
  int checks = 0;
  int errors = 0;
  logic [22:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  logic [15:0] regs_m [8];
  int err_m = 0;
  always #5 sys_clk = ~sys_clk;
  spi_afe_slave dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_clk_i(spi_clk_i), .spi_mosi_i(spi_mosi_i),
    .spi_sel_i(spi_sel_i), .spi_miso_o(spi_miso_o), .wr_strobe_o(wr_strobe_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .frame_err_cnt_o(frame_err_cnt_o), .busy_o(busy_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge sys_clk) begin
    if (!sys_rst && wr_strobe_o) begin
      if (exp_wr.size() == 0) check("wr_unexpected_pending", 32'(exp_wr.size()), 1);
      else begin
        logic [22:0] e;
        e = exp_wr.pop_front();
        check("wr_addr", 32'(wr_addr_o), 32'(e[22:16]));
        check("wr_data", 32'(wr_data_o), 32'(e[15:0]));
      end
    end
  end
  function automatic logic [15:0] rd_model(input logic [6:0] a);
    return a == 7'd0 ? 16'hAF01 : a < 7'd8 ? regs_m[a[2:0]] : 16'h0000;
  endfunction
  task automatic reset_checks();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_miso", 32'(spi_miso_o), 0);
    check("rst_strobe", 32'(wr_strobe_o), 0);
    check("rst_addr", 32'(wr_addr_o), 0);
    check("rst_data", 32'(wr_data_o), 0);
    check("rst_err", 32'(frame_err_cnt_o), 0);
  endtask
  task automatic xfer(input logic [23:0] w, input int nbits, input int rst_bit);
    logic [15:0] rd;
    rd = '0;
    spi_sel_i = 1'b0;
    #160;
    check("busy_frame", 32'(busy_o), 1);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = i < 24 ? w[23-i] : 1'b1;
      #80;
      if (i >= 8 && i < 24) rd = {rd[14:0], spi_miso_o};
      spi_clk_i = 1'b1;
      #80;
      spi_clk_i = 1'b0;
      if (i == rst_bit) begin
        sys_rst = 1'b1;
        #20;
        sys_rst = 1'b0;
        for (int k = 0; k < 8; k++) regs_m[k] = '0;
        err_m = 0;
        #10;
        reset_checks();
      end
    end
    #80;
    spi_sel_i = 1'b1;
    #200;
    check("busy_idle", 32'(busy_o), 0);
    if (w[23] && nbits == 24 && exp_rd.size() != 0) check("rd_data", 32'(rd), 32'(exp_rd.pop_front()));
  endtask
  task automatic do_write(input logic [6:0] a, input logic [15:0] d, input int nbits);
    if (nbits >= 24 && a != 7'd0 && a < 7'd8) begin
      exp_wr.push_back({a, d});
      regs_m[a[2:0]] = d;
    end
    if (nbits != 24 && nbits < 24 && err_m < 255) err_m++;
    xfer({1'b0, a, d}, nbits, -1);
  endtask
  task automatic do_read(input logic [6:0] a);
    exp_rd.push_back(rd_model(a));
    xfer({1'b1, a, 16'h0000}, 24, -1);
  endtask
  initial begin
    for (int k = 0; k < 8; k++) regs_m[k] = '0;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    #20;
    reset_checks();
    #100;
    do_write(7'd3, 16'hBEEF, 24);
    do_read(7'd3);
    do_read(7'd0);
    do_read(7'h40);
    do_write(7'd0, 16'h1111, 24);
    do_read(7'd0);
    check("err_after_addr0", 32'(frame_err_cnt_o), 32'(err_m));
    do_write(7'd7, 16'h5A5A, 24);
    do_write(7'd8, 16'h7777, 24);
    do_read(7'd7);
    do_write(7'd2, 16'hC3C3, 26);
    check("err_after_26clk", 32'(frame_err_cnt_o), 32'(err_m));
    do_read(7'd2);
    do_write(7'd4, 16'h1234, 20);
    do_write(7'd4, 16'h1234, 5);
    check("err_two_short", 32'(frame_err_cnt_o), 32'(err_m));
    for (int n = 0; n < 300; n++) do_write(7'd5, 16'hFFFF, 1);
    check("err_saturate", 32'(frame_err_cnt_o), 32'(err_m));
    xfer({1'b0, 7'd4, 16'hABCD}, 24, 12);
    check("err_after_reset", 32'(frame_err_cnt_o), 32'(err_m));
    do_write(7'd5, 16'h1234, 24);
    do_read(7'd5);
    do_read(7'd3);
    check("err_final", 32'(frame_err_cnt_o), 32'(err_m));
    check("wr_pending", 32'(exp_wr.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
